fir_mc_serial: RTL and testbench
================================

# fir_mc_serial

Multi-channel, time-multiplexed FIR filter with a valid/ready handshake; the parametrised successor to the single-channel serial filter in each equalizer band. One shared multiplier-accumulator serves all channels of a sample frame. Each channel has its own circular delay line, and every channel uses the same tap-coefficient set. It sits between the per-band input gain stage and the band summer, and can replace one filter instance per channel with a single instance per band.

## Interface
- `DATA_IN_BITS`, 16: signed input sample width per channel.
- `DATA_OUT_BITS`, 16: signed output sample width per channel.
- `NUMBER_OF_TAPS`, 64: number of FIR taps.
- `COUNTER_BITS`, 6: tap index / delay-pointer width, equal to clog2(`NUMBER_OF_TAPS`).
- `COEFF_BITS`, 16: signed coefficient width.
- `COEFF_FRAC_BITS`, 16: coefficient fractional bits; this is the output right-shift.
- `CHANNELS`, 2: channels per frame.
- `ACC_BITS`, 40: accumulator width; must be at least `DATA_IN_BITS` + `COEFF_BITS` + `COUNTER_BITS`.

- `clk`  in  1: single clock.
- `rst`  in  1: synchronous, active-high reset.
- `clk_enable`  in  1: global advance enable; when low, all state holds.
- `in_valid`  in  1: input frame valid.
- `in_ready`  out  1: block can accept a frame.
- `filter_in`  in  `CHANNELS`*`DATA_IN_BITS`: channel c occupies `[c*DATA_IN_BITS +: DATA_IN_BITS]`.
- `coeffs_feed`  in  `COEFF_BITS`*`NUMBER_OF_TAPS`: tap k occupies `[k*COEFF_BITS +: COEFF_BITS]`.
- `out_valid`  out  1: output frame valid, one-cycle pulse.
- `filter_out`  out  `CHANNELS`*`DATA_OUT_BITS`: packed the same way as `filter_in`.
- `busy`  out  1: high while a frame is being computed.

## Operation
- FSM states: IDLE, MAC, ROUND, OUT. Reset puts the FSM in IDLE.
- **Reset values:** `in_ready`=0 during reset and 1 afterwards; `out_valid`=0; `busy`=0; `filter_out`=0. Reset also zeroes all delay-line entries, the accumulators, the write pointer and the tap/channel counters.
- **IDLE:** `in_ready`=1. On an enabled cycle with `in_valid`=1:
  - advance the write pointer by 1 (mod `NUMBER_OF_TAPS`);
  - write each channel's sample at the new pointer;
  - clear the accumulators, zero the tap counter k and the channel counter c, then go to MAC.
- **MAC:** one product per enabled cycle.
  - Operation: acc[c] += x_c[wp - k mod N] * coeff[k].
  - Order: c is the outer loop, k the inner loop (k runs 0..N-1 for c=0, then for c=1, and so on).
  - After the final product (c = `CHANNELS`-1, k = N-1), go to ROUND.
- **ROUND:** for each channel, compute y = (acc + 2^(`COEFF_FRAC_BITS`-1)) >>> `COEFF_FRAC_BITS`, an arithmetic shift with round-half-up. Saturate y to [-2^(`DATA_OUT_BITS`-1), 2^(`DATA_OUT_BITS`-1) - 1], register it into `filter_out`, then go to OUT.
- **OUT:** `out_valid`=1 for one enabled cycle, then go to IDLE. `filter_out` holds its value until the next ROUND.
- **Arithmetic:**
  - Each product is full precision: `DATA_IN_BITS`+`COEFF_BITS` bits, signed.
  - Products are sign-extended to `ACC_BITS`; accumulation wraps, with no saturation before ROUND.
- **Coefficients:** `coeffs_feed` is read combinationally during MAC. The driver keeps it stable while `busy`=1. If it changes mid-frame, the result mixes old and new coefficients; this is defined as allowed and is not an error.
- `busy` = (state != IDLE).
- `in_ready` = (state == IDLE) and not `rst`. `in_valid` is ignored outside IDLE, and no frame is lost through back-pressure.
- **`clk_enable`=0:** FSM, counters, accumulators, delay lines and outputs all hold. A pending `out_valid`=1 stays high until one enabled cycle has passed.
- **Mid-operation `rst`:** the frame is abandoned, no `out_valid` is produced, and the delay lines are cleared.

## Timing
- Count enabled cycles only; disabled cycles stretch every interval below.
- Frame accepted at cycle T (IDLE handshake).
- MAC covers T+1 … T+`CHANNELS`*N.
- ROUND at T+`CHANNELS`*N+1.
- `out_valid`=1 at T+`CHANNELS`*N+2.
- Latency from acceptance to `out_valid` is therefore `CHANNELS`*N+2 cycles: 130 at the defaults.
- `in_ready` rises at T+`CHANNELS`*N+3. The minimum frame period is `CHANNELS`*N+3 cycles (131 at the defaults).

## Test plan
- **Impulse response.** Setup: coeff[k] = k*256, ch0 impulse 16'sh4000 then zeros, ch1 all zeros. Required: ch0 outputs 64*k on frame k for k=0..63, then 0. ch1 stays 0. `out_valid` arrives exactly 130 cycles after each handshake.
- **DC settling.** Setup: all coeffs 16'h0400 (1/64), both channels held at 16'sh1000. Required: output ramps by 64 per frame and reaches 16'sh1000 at frame 63, then holds.
- **Saturation.** Setup: all coeffs 16'sh7FFF, input 16'sh7FFF for 64 frames. Required: output 16'sh7FFF. With input 16'sh8000, required output is 16'sh8000; no wrap is allowed.
- **Channel independence.** Setup: ch0 impulse, ch1 constant -16'sd256, coeff[0]=16'sh8000, other coeffs 0. Required: ch1 outputs +128 every frame; ch0 outputs -8192 on frame 0 and 0 afterwards.
- **Stalls and back-pressure.** Setup: randomly toggle `clk_enable` (50%) and `in_valid`. Required: outputs match a golden model bit-exactly, no frame is dropped or duplicated, and `in_ready` is never high while `busy`=1.
- **Reset mid-MAC.** Setup: assert `rst` for 1 cycle at k=30 of a frame. Required: no `out_valid` for that frame, `filter_out`=0, and `in_ready`=1 on the next cycle. A subsequent impulse produces the same response as from power-up.

Source files
------------

// File: rtl/fir_mc_serial.sv
// Time-multiplexed multi-channel FIR: one shared MAC walks every tap of every channel per frame,
// then rounds and saturates all channels at once and presents them with a one-cycle valid pulse.
module fir_mc_serial #(
    parameter int DATA_IN_BITS    = 16,
    parameter int DATA_OUT_BITS   = 16,
    parameter int NUMBER_OF_TAPS  = 64,
    parameter int COUNTER_BITS    = 6,
    parameter int COEFF_BITS      = 16,
    parameter int COEFF_FRAC_BITS = 16,
    parameter int CHANNELS        = 2,
    parameter int ACC_BITS        = 40
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clk_enable,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [CHANNELS*DATA_IN_BITS-1:0]     filter_in,
    input  logic [COEFF_BITS*NUMBER_OF_TAPS-1:0] coeffs_feed,
    output logic                                 out_valid,
    output logic [CHANNELS*DATA_OUT_BITS-1:0]    filter_out,
    output logic                                 busy
);
    // state | meaning
    // IDLE  | waiting for a frame; in_ready high
    // MAC   | one product per cycle, channel outer loop, tap inner loop
    // ROUND | round, saturate and register every channel
    // OUT   | out_valid pulse
    typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_t;

    localparam int PROD_BITS = DATA_IN_BITS + COEFF_BITS;
    localparam int CH_BITS   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [COUNTER_BITS-1:0] K_LAST = COUNTER_BITS'(NUMBER_OF_TAPS - 1);
    localparam logic [CH_BITS-1:0]      C_LAST = CH_BITS'(CHANNELS - 1);
    localparam logic [COUNTER_BITS:0]   N_EXT  = (COUNTER_BITS + 1)'(NUMBER_OF_TAPS);
    localparam logic signed [ACC_BITS:0] HALF  = $signed((ACC_BITS + 1)'(1) << (COEFF_FRAC_BITS - 1));
    localparam logic signed [ACC_BITS:0] Y_MAX = $signed((ACC_BITS + 1)'((64'sd1 <<< (DATA_OUT_BITS - 1)) - 64'sd1));
    localparam logic signed [ACC_BITS:0] Y_MIN = ~Y_MAX;

    state_t                           state_q, state_d;
    logic [COUNTER_BITS-1:0]          wp_q, wp_d, k_q, k_d, rd_idx;
    logic [CH_BITS-1:0]               c_q, c_d;
    logic [COUNTER_BITS:0]            rd_sum;
    logic signed [DATA_IN_BITS-1:0]   dl_q [CHANNELS][NUMBER_OF_TAPS];
    logic signed [DATA_IN_BITS-1:0]   dl_d [CHANNELS][NUMBER_OF_TAPS];
    logic signed [ACC_BITS-1:0]       acc_q [CHANNELS];
    logic signed [ACC_BITS-1:0]       acc_d [CHANNELS];
    logic [CHANNELS*DATA_OUT_BITS-1:0] fout_q, fout_d;
    logic signed [DATA_IN_BITS-1:0]   x_sel;
    logic signed [COEFF_BITS-1:0]     c_sel;
    logic signed [PROD_BITS-1:0]      prod;
    logic signed [ACC_BITS:0]         rnd, shf;

    // Newest sample sits at wp; tap k reads wp - k modulo the line length.
    always_comb begin
        rd_sum = {1'b0, wp_q} + N_EXT - {1'b0, k_q};
        rd_idx = COUNTER_BITS'((rd_sum >= N_EXT) ? rd_sum - N_EXT : rd_sum);
        x_sel  = dl_q[c_q][rd_idx];
        c_sel  = coeffs_feed[int'(k_q)*COEFF_BITS +: COEFF_BITS];
        prod   = x_sel * c_sel;
    end

    always_comb begin
        state_d = state_q;
        wp_d    = wp_q;
        k_d     = k_q;
        c_d     = c_q;
        dl_d    = dl_q;
        acc_d   = acc_q;
        fout_d  = fout_q;
        rnd     = '0;
        shf     = '0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    wp_d = (wp_q == K_LAST) ? '0 : wp_q + 1'b1;
                    for (int ch = 0; ch < CHANNELS; ch++) begin
                        dl_d[ch][wp_d] = filter_in[ch*DATA_IN_BITS +: DATA_IN_BITS];
                        acc_d[ch]      = '0;
                    end
                    k_d     = '0;
                    c_d     = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d[c_q] = acc_q[c_q] + {{(ACC_BITS-PROD_BITS){prod[PROD_BITS-1]}}, prod};
                if (k_q == K_LAST) begin
                    k_d = '0;
                    if (c_q == C_LAST) state_d = ROUND;
                    else c_d = c_q + 1'b1;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ROUND: begin
                for (int ch = 0; ch < CHANNELS; ch++) begin
                    rnd = {acc_q[ch][ACC_BITS-1], acc_q[ch]} + HALF;
                    shf = rnd >>> COEFF_FRAC_BITS;
                    if (shf > Y_MAX)
                        fout_d[ch*DATA_OUT_BITS +: DATA_OUT_BITS] = {1'b0, {(DATA_OUT_BITS-1){1'b1}}};
                    else if (shf < Y_MIN)
                        fout_d[ch*DATA_OUT_BITS +: DATA_OUT_BITS] = {1'b1, {(DATA_OUT_BITS-1){1'b0}}};
                    else
                        fout_d[ch*DATA_OUT_BITS +: DATA_OUT_BITS] = shf[DATA_OUT_BITS-1:0];
                end
                state_d = OUT;
            end
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wp_q    <= '0;
            k_q     <= '0;
            c_q     <= '0;
            fout_q  <= '0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                acc_q[ch] <= '0;
                for (int t = 0; t < NUMBER_OF_TAPS; t++) dl_q[ch][t] <= '0;
            end
        end else if (clk_enable) begin
            state_q <= state_d;
            wp_q    <= wp_d;
            k_q     <= k_d;
            c_q     <= c_d;
            fout_q  <= fout_d;
            acc_q   <= acc_d;
            dl_q    <= dl_d;
        end
    end

    assign in_ready   = (state_q == IDLE) && !rst;
    assign busy       = (state_q != IDLE);
    assign out_valid  = (state_q == OUT);
    assign filter_out = fout_q;
endmodule

// File: tb/tb_fir_mc_serial.sv
// Directed bench for fir_mc_serial: impulse, DC, saturation, channel independence,
// random stalls against a shift-register reference, and reset in the middle of a frame.
module tb_fir_mc_serial;
    localparam int N  = 64;
    localparam int NF = 24;

    logic          clk = 1'b0;
    logic          rst, clk_enable, in_valid;
    logic          in_ready, out_valid, busy;
    logic [31:0]   filter_in, filter_out;
    logic [1023:0] coeffs;

    int total = 0;
    int bad   = 0;

    logic signed [15:0] h0 [N];
    logic signed [15:0] h1 [N];
    logic [15:0] nx0, nx1;
    int exp_q0[$], exp_q1[$];
    int sent, recv, cyc, extra, n;

    always #5 clk = ~clk;

    fir_mc_serial dut (
        .clk(clk), .rst(rst), .clk_enable(clk_enable), .in_valid(in_valid),
        .in_ready(in_ready), .filter_in(filter_in), .coeffs_feed(coeffs),
        .out_valid(out_valid), .filter_out(filter_out), .busy(busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; clk_enable = 1'b1; in_valid = 1'b0;
        step(); step();
        chk("rst.in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst.busy", {31'b0, busy}, 32'd0);
        chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst.filter_out", filter_out, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst.ready_after", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic run_frame(input logic [15:0] x0, input logic [15:0] x1,
                             input int e0, input int e1, input string tag);
        int m;
        m = 0;
        while (!in_ready && m < 400) begin step(); m++; end
        chk({tag, ".ready"}, {31'b0, in_ready}, 32'd1);
        filter_in = {x1, x0};
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        m = 1;
        while (!out_valid && m < 400) begin step(); m++; end
        chk({tag, ".latency"}, 32'(m), 32'd130);
        chk({tag, ".ch0"}, {16'b0, filter_out[15:0]}, {16'b0, 16'(e0)});
        chk({tag, ".ch1"}, {16'b0, filter_out[31:16]}, {16'b0, 16'(e1)});
        step();
    endtask

    function automatic int ref_y(input longint acc);
        longint r;
        r = (acc + 64'sd32768) >>> 16;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    task automatic set_ramp();
        for (int k = 0; k < N; k++) coeffs[k*16 +: 16] = 16'(k * 256);
    endtask

    task automatic model_push(input logic [15:0] x0, input logic [15:0] x1);
        longint a0, a1;
        for (int k = N - 1; k > 0; k--) begin h0[k] = h0[k-1]; h1[k] = h1[k-1]; end
        h0[0] = x0; h1[0] = x1;
        a0 = 0; a1 = 0;
        for (int k = 0; k < N; k++) begin
            a0 += longint'(h0[k]) * longint'(k * 256);
            a1 += longint'(h1[k]) * longint'(k * 256);
        end
        exp_q0.push_back(ref_y(a0));
        exp_q1.push_back(ref_y(a1));
    endtask

    initial begin
        rst = 1'b1; clk_enable = 1'b1; in_valid = 1'b0; filter_in = '0; coeffs = '0;

        // impulse response
        set_ramp();
        do_reset();
        for (int f = 0; f < 66; f++)
            run_frame((f == 0) ? 16'h4000 : 16'h0000, 16'h0000, (f < 64) ? 64 * f : 0, 0,
                      $sformatf("imp%0d", f));

        // DC settling
        for (int k = 0; k < N; k++) coeffs[k*16 +: 16] = 16'h0400;
        do_reset();
        for (int f = 0; f < 66; f++)
            run_frame(16'h1000, 16'h1000, (f < 63) ? 64 * (f + 1) : 4096,
                      (f < 63) ? 64 * (f + 1) : 4096, $sformatf("dc%0d", f));

        // saturation, both polarities
        for (int k = 0; k < N; k++) coeffs[k*16 +: 16] = 16'h7FFF;
        do_reset();
        for (int f = 0; f < 64; f++)
            run_frame(16'h7FFF, 16'h7FFF, (f == 0) ? 16383 : (f == 1) ? 32766 : 32767,
                      (f == 0) ? 16383 : (f == 1) ? 32766 : 32767, $sformatf("satp%0d", f));
        do_reset();
        for (int f = 0; f < 64; f++)
            run_frame(16'h8000, 16'h8000, (f == 0) ? -16383 : (f == 1) ? -32767 : -32768,
                      (f == 0) ? -16383 : (f == 1) ? -32767 : -32768, $sformatf("satn%0d", f));

        // channel independence
        coeffs = '0;
        coeffs[15:0] = 16'h8000;
        do_reset();
        run_frame(16'h4000, 16'hFF00, -8192, 128, "ind0");
        run_frame(16'h0000, 16'hFF00, 0, 128, "ind1");
        run_frame(16'h0000, 16'hFF00, 0, 128, "ind2");

        // random stalls and back-pressure
        set_ramp();
        do_reset();
        for (int k = 0; k < N; k++) begin h0[k] = '0; h1[k] = '0; end
        sent = 0; recv = 0; cyc = 0;
        nx0 = 16'($urandom); nx1 = 16'($urandom);
        while (recv < NF && cyc < 20000) begin
            chk("stall.ready_busy", {31'b0, in_ready & busy}, 32'd0);
            clk_enable = 1'($urandom_range(0, 1));
            in_valid   = (sent < NF) && ($urandom_range(0, 3) != 0);
            filter_in  = {nx1, nx0};
            if (out_valid && clk_enable) begin
                if (exp_q0.size() == 0) begin
                    chk("stall.dup", 32'(recv), 32'(sent));
                end else begin
                    chk($sformatf("stall%0d.ch0", recv), {16'b0, filter_out[15:0]}, {16'b0, 16'(exp_q0[0])});
                    chk($sformatf("stall%0d.ch1", recv), {16'b0, filter_out[31:16]}, {16'b0, 16'(exp_q1[0])});
                    void'(exp_q0.pop_front());
                    void'(exp_q1.pop_front());
                end
                recv++;
            end
            if (in_valid && in_ready && clk_enable) begin
                model_push(nx0, nx1);
                sent++;
                nx0 = 16'($urandom); nx1 = 16'($urandom);
            end
            step();
            cyc++;
        end
        chk("stall.recv", 32'(recv), 32'(NF));
        chk("stall.sent", 32'(sent), 32'(NF));
        clk_enable = 1'b1; in_valid = 1'b0;
        extra = 0;
        for (int i = 0; i < 200; i++) begin
            if (out_valid) extra++;
            step();
        end
        chk("stall.extra_out", 32'(extra), 32'd0);

        // reset in the middle of a frame
        set_ramp();
        do_reset();
        run_frame(16'h1000, 16'h1000, 0, 0, "rm.warm0");
        run_frame(16'h1000, 16'h1000, 16, 16, "rm.warm1");
        n = 0;
        while (!in_ready && n < 400) begin step(); n++; end
        filter_in = 32'h1000_1000;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        for (int i = 0; i < 30; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rm.out_valid", {31'b0, out_valid}, 32'd0);
        chk("rm.filter_out", filter_out, 32'd0);
        chk("rm.busy", {31'b0, busy}, 32'd0);
        chk("rm.in_ready", {31'b0, in_ready}, 32'd1);
        extra = 0;
        for (int i = 0; i < 140; i++) begin
            if (out_valid) extra++;
            step();
        end
        chk("rm.no_out", 32'(extra), 32'd0);
        run_frame(16'h4000, 16'h0000, 0, 0, "rm.imp0");
        run_frame(16'h0000, 16'h0000, 64, 0, "rm.imp1");
        run_frame(16'h0000, 16'h0000, 128, 0, "rm.imp2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
